// File: rtl/pe_psum_if.sv
// pe_psum_if: PE-side and output-side handshake bundle for pe_psum_collector.
// The master view belongs to the collector; the slave view belongs to the
// feeder/PE/writer environment around it.
interface pe_psum_if;
  logic               in_valid;
  logic               in_ready;
  logic               pe_stall;
  logic signed [31:0] pe_psum;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               ovf;

  modport master (
    input  in_valid,
    input  pe_psum,
    input  out_ready,
    output in_ready,
    output pe_stall,
    output out_valid,
    output out_data,
    output ovf
  );

  modport slave (
    output in_valid,
    output pe_psum,
    output out_ready,
    input  in_ready,
    input  pe_stall,
    input  out_valid,
    input  out_data,
    input  ovf
  );
endinterface

// File: rtl/pe_psum_collector.sv
// pe_psum_collector: tracks valid PE pipeline slots, accumulates ACC_LEN
// partial sums into a saturated 32-bit result and presents it on a
// valid/ready port, stalling the PE only when a finishing partial sum would
// overwrite an undrained result.
// Optional feature: define PSUM_RELU_EN to clamp negative results to zero
// on output (the ovf flag still reflects the unclamped sum).
module pe_psum_collector #(
  parameter int ACC_LEN = 3,
  parameter int PE_LAT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  pe_psum_if.master   bus
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  // 33-bit sign-extended add so the true sum is always representable
  function automatic logic signed [32:0] add33(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    return {a[31], a} + {b[31], b};
  endfunction

  // A 33-bit sum is outside the 32-bit range when its top two bits differ
  function automatic logic is_clamped(input logic signed [32:0] s);
    return s[32] ^ s[31];
  endfunction

  // Clamp a 33-bit sum to [-2^31, 2^31-1]
  function automatic logic signed [31:0] sat32(input logic signed [32:0] s);
    if (is_clamped(s))
      return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[31:0];
  endfunction

`ifdef PSUM_RELU_EN
  function automatic logic signed [31:0] relu(input logic signed [31:0] x);
    return x[31] ? 32'sd0 : x;
  endfunction
`endif

  logic [PE_LAT-1:0]  vld;
  logic [CNT_W-1:0]   cnt;
  logic signed [31:0] acc;
  logic signed [31:0] out_data_q;
  logic               out_valid_q;
  logic               ovf_q;

  logic               head;
  logic               last;
  logic               first;
  logic               pe_stall;
  logic               take;
  logic signed [32:0] sum33;
  logic signed [31:0] final_sum;
  logic signed [31:0] out_load;
  logic               clip;

  // Stall, accept and next-value decode; stall never depends on in_valid
  always_comb begin
    head      = vld[PE_LAT-1];
    last      = (cnt == CNT_LAST);
    first     = (cnt == '0);
    pe_stall  = out_valid_q & ~bus.out_ready & head & last;
    take      = head & ~pe_stall;
    sum33     = add33(acc, bus.pe_psum);
    final_sum = first ? bus.pe_psum : sat32(sum33);
    clip      = ~first & is_clamped(sum33);
`ifdef PSUM_RELU_EN
    out_load  = relu(final_sum);
`else
    out_load  = final_sum;
`endif
  end

  assign bus.pe_stall  = pe_stall;
  assign bus.in_ready  = ~pe_stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;

  // ---- stage boundary: valid tracker mirrors the PE pipeline ----
  // Valid shift register advances only when the PE advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (!pe_stall) begin
      vld[0] <= bus.in_valid;
      for (int i = 1; i < PE_LAT; i++)
        vld[i] <= vld[i-1];
    end
  end

  // ---- stage boundary: accumulation of taken partial sums ----
  // Group counter and running saturated accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (take) begin
      if (last) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= final_sum;
      end
    end
  end

  // Sticky saturation flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (take && clip)
      ovf_q <= 1'b1;
  end

  // ---- stage boundary: output register with valid/ready handshake ----
  // Load on group completion (even while draining); otherwise clear on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (take && last) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_load;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
